// File: rtl/mdu_seq_pkg.sv
// Shared definitions (package p_hardisc) for the sequential multiply/divide unit:
// function codes, FSM states and iteration-count helper.
package p_hardisc;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_fn;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state;

    // Iteration count for a datapath retiring `step` bits per cycle.
    function automatic int mdu_cycles(input int xlen, input int step);
        return xlen / step;
    endfunction

    function automatic logic mdu_is_div(input mdu_fn fn);
        return fn[2];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic mdu_op1_signed(input mdu_fn fn);
        return (fn == MDU_MUL) || (fn == MDU_MULH) || (fn == MDU_MULHSU) ||
               (fn == MDU_DIV) || (fn == MDU_REM);
    endfunction

    function automatic logic mdu_op2_signed(input mdu_fn fn);
        return (fn == MDU_MUL) || (fn == MDU_MULH) ||
               (fn == MDU_DIV) || (fn == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// Combinational restoring-division step retiring DIV_STEP quotient bits,
// dividend bits consumed MSB first.
module mdu_div_step
    import p_hardisc::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1
) (
    input  logic [XLEN:0]       partial_rem,
    input  logic [XLEN-1:0]     divisor,
    input  logic [DIV_STEP-1:0] dividend_bits,
    output logic [XLEN:0]       next_rem,
    output logic [DIV_STEP-1:0] quot_bits
);

    logic [XLEN:0] rem_work;
    logic [XLEN:0] shifted;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        rem_work  = partial_rem;
        shifted   = '0;
        quot_bits = '0;
        for (int i = DIV_STEP - 1; i >= 0; i--) begin
            shifted = {rem_work[XLEN-1:0], dividend_bits[i]};
            if (shifted >= {1'b0, divisor}) begin
                rem_work     = shifted - {1'b0, divisor};
                quot_bits[i] = 1'b1;
            end else begin
                rem_work     = shifted;
                quot_bits[i] = 1'b0;
            end
        end
        next_rem = rem_work;
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M/RV64M multiply/divide unit with configurable bits per cycle.
// Optional one-cycle early-out for trivial operands: define MDU_EARLY_OUT_EN.
module mdu_seq
    import p_hardisc::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int DIV_STEP = 1
) (
    input  logic            s_clk_i,
    input  logic            s_reset_i,
    input  logic            s_start_i,
    input  logic            s_stall_i,
    input  logic            s_flush_i,
    input  logic [2:0]      s_function_i,
    input  logic [XLEN-1:0] s_operand1_i,
    input  logic [XLEN-1:0] s_operand2_i,
    output logic            s_finished_o,
    output logic [XLEN-1:0] s_result_o,
    output logic            s_busy_o
);

    localparam int MDU_MUL_CYC = mdu_cycles(XLEN, MUL_STEP);
    localparam int MDU_DIV_CYC = mdu_cycles(XLEN, DIV_STEP);
    localparam int CNT_W       = $clog2(XLEN + 1);

    mdu_state          state;
    mdu_fn             fn;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mcand;      // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] prod;       // {accumulator, remaining multiplier bits}
    logic [XLEN:0]     rem;
    logic [XLEN-1:0]   quo;        // dividend bits shift out as quotient bits shift in
    logic              neg_lo;     // negate product / quotient in FIX
    logic              neg_rem;

    // Operand preparation while IDLE.
    mdu_fn           fn_in;
    logic            sgn1, sgn2;
    logic [XLEN-1:0] mag1, mag2;

    assign fn_in = mdu_fn'(s_function_i);
    assign sgn1  = s_operand1_i[XLEN-1] & mdu_op1_signed(fn_in);
    assign sgn2  = s_operand2_i[XLEN-1] & mdu_op2_signed(fn_in);
    assign mag1  = sgn1 ? -s_operand1_i : s_operand1_i;
    assign mag2  = sgn2 ? -s_operand2_i : s_operand2_i;

`ifdef MDU_EARLY_OUT_EN
    logic early_mul_zero, early_div_zero, early_ovf;

    assign early_mul_zero = !mdu_is_div(fn_in) &&
                            ((s_operand1_i == '0) || (s_operand2_i == '0));
    assign early_div_zero = mdu_is_div(fn_in) && (s_operand2_i == '0);
    assign early_ovf      = ((fn_in == MDU_DIV) || (fn_in == MDU_REM)) &&
                            (s_operand1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                            (s_operand2_i == '1);
`endif

    // Multiply step: add MUL_STEP shifted partial products to the upper half,
    // then shift the whole product register right by MUL_STEP.
    logic [XLEN+MUL_STEP-1:0]   partial;
    logic [2*XLEN+MUL_STEP-1:0] mul_wide;
    logic [2*XLEN-1:0]          prod_next;

    always_comb begin
        partial = {{MUL_STEP{1'b0}}, prod[2*XLEN-1:XLEN]};
        for (int j = 0; j < MUL_STEP; j++) begin
            if (prod[j])
                partial = partial + ((XLEN+MUL_STEP)'(mcand) << j);
        end
        mul_wide  = {partial, prod[XLEN-1:0]};
        prod_next = mul_wide[2*XLEN+MUL_STEP-1:MUL_STEP];
    end

    logic [XLEN:0]       rem_next;
    logic [DIV_STEP-1:0] qbits;
    logic [XLEN-1:0]     quo_next;

    mdu_div_step #(
        .XLEN     (XLEN),
        .DIV_STEP (DIV_STEP)
    ) u_div_step (
        .partial_rem   (rem),
        .divisor       (mcand),
        .dividend_bits (quo[XLEN-1 -: DIV_STEP]),
        .next_rem      (rem_next),
        .quot_bits     (qbits)
    );

    assign quo_next = {quo[XLEN-DIV_STEP-1:0], qbits};

    // Sign correction and half selection.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = neg_lo  ? -prod : prod;
        quo_fix  = neg_lo  ? -quo  : quo;
        rem_fix  = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        case (fn)
            MDU_MUL:                         fix_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               fix_result = quo_fix;
            default:                         fix_result = rem_fix;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state        <= IDLE;
            fn           <= MDU_MUL;
            cnt          <= '0;
            mcand        <= '0;
            prod         <= '0;
            rem          <= '0;
            quo          <= '0;
            neg_lo       <= 1'b0;
            neg_rem      <= 1'b0;
            s_finished_o <= 1'b0;
            s_result_o   <= '0;
            s_busy_o     <= 1'b0;
        end else if (s_flush_i) begin
            state        <= IDLE;
            s_finished_o <= 1'b0;
            s_busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_start_i) begin
                        fn       <= fn_in;
                        cnt      <= '0;
                        s_busy_o <= 1'b1;
                        if (mdu_is_div(fn_in)) begin
                            mcand   <= mag2;
                            quo     <= mag1;
                            rem     <= '0;
                            // A zero divisor leaves the quotient as all ones, unsigned.
                            neg_lo  <= (sgn1 ^ sgn2) & (s_operand2_i != '0);
                            neg_rem <= sgn1;
                            state   <= DIV;
                        end else begin
                            mcand   <= mag1;
                            prod    <= {{XLEN{1'b0}}, mag2};
                            neg_lo  <= sgn1 ^ sgn2;
                            neg_rem <= 1'b0;
                            state   <= MUL;
                        end
`ifdef MDU_EARLY_OUT_EN
                        if (early_mul_zero) begin
                            prod   <= '0;
                            neg_lo <= 1'b0;
                            state  <= FIX;
                        end else if (early_div_zero) begin
                            quo   <= '1;
                            rem   <= {1'b0, mag1};
                            state <= FIX;
                        end else if (early_ovf) begin
                            quo   <= mag1;
                            rem   <= '0;
                            state <= FIX;
                        end
`endif
                    end
                end
                MUL: begin
                    prod <= prod_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(MDU_MUL_CYC - 1))
                        state <= FIX;
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MDU_DIV_CYC - 1))
                        state <= FIX;
                end
                FIX: begin
                    s_result_o   <= fix_result;
                    s_finished_o <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (!s_stall_i) begin
                        s_finished_o <= 1'b0;
                        s_busy_o     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    s_busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq (XLEN=32, MUL_STEP=4, DIV_STEP=1): vector table,
// directed stall/flush/reset sequences and random operations against a reference model.
module tb_mdu_seq;
    import p_hardisc::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      fn_sel = '0;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic            finished;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_seq #(
        .XLEN     (XLEN),
        .MUL_STEP (4),
        .DIV_STEP (1)
    ) dut (
        .s_clk_i      (clk),
        .s_reset_i    (rst),
        .s_start_i    (start),
        .s_stall_i    (stall),
        .s_flush_i    (flush),
        .s_function_i (fn_sel),
        .s_operand1_i (op1),
        .s_operand2_i (op2),
        .s_finished_o (finished),
        .s_result_o   (result),
        .s_busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // Posedges from the start-sampling edge up to and including the one that raises finished.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if (f < 4 && (a == 0 || b == 0)) return 2;
        if (f >= 4 && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`endif
        return (f < 4) ? (32 / 4 + 2) : (32 / 1 + 2);
    endfunction

    // Start one operation and wait (bounded) for finished; lat = -1 on timeout.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        fn_sel = f; op1 = a; op2 = b; start = 1'b1;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (finished) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] res, held;
        int          lat;
        logic        seen_fin;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{MDU_MUL,    32'h0000_1234, 32'h0000_0010, 32'h0001_2340};
        vecs[1]  = '{MDU_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{MDU_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        vecs[3]  = '{MDU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[4]  = '{MDU_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{MDU_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{MDU_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF};
        vecs[7]  = '{MDU_REMU,   32'd100,       32'd0,         32'd100};
        vecs[8]  = '{MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{MDU_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        vecs[11] = '{MDU_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
        vecs[12] = '{MDU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[13] = '{MDU_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555};
        vecs[14] = '{MDU_REMU,   32'hFFFF_FFFF, 32'd10,        32'd5};
        vecs[15] = '{MDU_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[16] = '{MDU_MUL,    32'h0000_1234, 32'd0,         32'd0};
        vecs[17] = '{MDU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1};
        vecs[18] = '{MDU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};

        // Reset state.
        #6;
        check("reset_finished", {63'd0, finished}, 64'd0);
        check("reset_result",   {32'd0, result},   64'd0);
        check("reset_busy",     {63'd0, busy},     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table: result, latency, single-cycle finished, return to IDLE.
        foreach (vecs[i]) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), {32'd0, res}, {32'd0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_fin_drop", i), {63'd0, finished}, 64'd0);
            check($sformatf("vec%0d_idle", i), {63'd0, busy}, 64'd0);
        end

        // Stall in DONE: finished and result hold for three cycles, IDLE after stall drops.
        stall = 1'b1;
        do_op(MDU_DIV, 32'd1000, 32'd7, res, lat);
        check("stall_result", {32'd0, res}, 64'd142);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_fin_c%0d", c), {63'd0, finished}, 64'd1);
            check($sformatf("stall_res_c%0d", c), {32'd0, result}, 64'd142);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("stall_release_busy", {63'd0, busy}, 64'd0);
        check("stall_release_fin", {63'd0, finished}, 64'd0);

        // Flush at iteration 5 of a DIV.
        held = result;
        @(negedge clk);
        fn_sel = MDU_DIV; op1 = 32'd5000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_fin", {63'd0, finished}, 64'd0);
        check("flush_result_held", {32'd0, result}, {32'd0, held});
        seen_fin = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (finished) seen_fin = 1'b1;
        end
        check("flush_no_finish", {63'd0, seen_fin}, 64'd0);
        do_op(MDU_MUL, 32'd3, 32'd5, res, lat);
        check("post_flush_mul", {32'd0, res}, 64'd15);
        check("post_flush_lat", 64'(lat), 64'(exp_lat(MDU_MUL, 32'd3, 32'd5)));
        @(posedge clk);

        // Asynchronous reset mid-MUL.
        @(negedge clk);
        fn_sel = MDU_MUL; op1 = 32'd77; op2 = 32'd99; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_result", {32'd0, result}, 64'd0);
        check("async_rst_fin", {63'd0, finished}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op(rf, ra, rb, res, lat);
            check($sformatf("rnd%0d_f%0d_%h_%h", n, rf, ra, rb), {32'd0, res}, {32'd0, model(rf, ra, rb)});
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(exp_lat(rf, ra, rb)));
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
